rvfi_retire_tracker: RTL

- Downstream consumer of the RVFI probe signals.
- Captures per-transaction issue-time data (instruction word, operand values, LSU access) in a table indexed by scoreboard trans_id.
- Joins that data with commit-port information and emits one registered RVFI retirement record per committed, non-dropped instruction, in program order, with a monotonically increasing order number.
- Sits between the core probe tap and the RVFI trace/checker interface.

---
 rtl/rvfi_retire_tracker_if.sv | 66 ++++++
 rtl/rvfi_retire_tracker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_retire_tracker_if.sv
// Bundle of the probe-side inputs (issue, LSU, commit) and the RVFI record outputs
// of rvfi_retire_tracker.
//   slave  : tracker view (probe signals in, RVFI records out)
//   master : probe/trace environment view (probe signals out, RVFI records in)
interface rvfi_retire_tracker_if #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned TRANS_ID_BITS   = 3,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned ILEN            = 32
) ();
    logic                                flush_i;
    logic                                issue_valid_i;
    logic [TRANS_ID_BITS-1:0]            issue_pointer_i;
    logic [ILEN-1:0]                     instruction_i;
    logic                                is_compressed_i;
    logic [XLEN-1:0]                     rs1_fwd_i;
    logic [XLEN-1:0]                     rs2_fwd_i;
    logic                                lsu_valid_i;
    logic [TRANS_ID_BITS-1:0]            lsu_trans_id_i;
    logic                                lsu_is_store_i;
    logic [XLEN-1:0]                     lsu_vaddr_i;
    logic [XLEN/8-1:0]                   lsu_be_i;
    logic [NR_COMMIT_PORTS-1:0]          commit_ack_i;
    logic [NR_COMMIT_PORTS-1:0]          commit_drop_i;
    logic [NR_COMMIT_PORTS*TRANS_ID_BITS-1:0] commit_pointer_i;
    logic [NR_COMMIT_PORTS*XLEN-1:0]     commit_pc_i;
    logic [NR_COMMIT_PORTS*5-1:0]        commit_rd_i;
    logic [NR_COMMIT_PORTS*XLEN-1:0]     commit_wdata_i;
    logic                                ex_valid_i;
    logic [1:0]                          priv_lvl_i;

    logic [NR_COMMIT_PORTS-1:0]          rvfi_valid_o;
    logic [NR_COMMIT_PORTS*64-1:0]       rvfi_order_o;
    logic [NR_COMMIT_PORTS*ILEN-1:0]     rvfi_insn_o;
    logic [NR_COMMIT_PORTS-1:0]          rvfi_trap_o;
    logic [NR_COMMIT_PORTS*XLEN-1:0]     rvfi_pc_o;
    logic [NR_COMMIT_PORTS*5-1:0]        rvfi_rd_addr_o;
    logic [NR_COMMIT_PORTS*XLEN-1:0]     rvfi_rd_wdata_o;
    logic [NR_COMMIT_PORTS*XLEN-1:0]     rvfi_rs1_rdata_o;
    logic [NR_COMMIT_PORTS*XLEN-1:0]     rvfi_rs2_rdata_o;
    logic [NR_COMMIT_PORTS*XLEN-1:0]     rvfi_mem_addr_o;
    logic [NR_COMMIT_PORTS*XLEN/8-1:0]   rvfi_mem_rmask_o;
    logic [NR_COMMIT_PORTS*XLEN/8-1:0]   rvfi_mem_wmask_o;
    logic [NR_COMMIT_PORTS*2-1:0]        rvfi_mode_o;
    logic                                miss_o;

    modport slave (
        input  flush_i, issue_valid_i, issue_pointer_i, instruction_i, is_compressed_i,
               rs1_fwd_i, rs2_fwd_i, lsu_valid_i, lsu_trans_id_i, lsu_is_store_i,
               lsu_vaddr_i, lsu_be_i, commit_ack_i, commit_drop_i, commit_pointer_i,
               commit_pc_i, commit_rd_i, commit_wdata_i, ex_valid_i, priv_lvl_i,
        output rvfi_valid_o, rvfi_order_o, rvfi_insn_o, rvfi_trap_o, rvfi_pc_o,
               rvfi_rd_addr_o, rvfi_rd_wdata_o, rvfi_rs1_rdata_o, rvfi_rs2_rdata_o,
               rvfi_mem_addr_o, rvfi_mem_rmask_o, rvfi_mem_wmask_o, rvfi_mode_o, miss_o
    );

    modport master (
        output flush_i, issue_valid_i, issue_pointer_i, instruction_i, is_compressed_i,
               rs1_fwd_i, rs2_fwd_i, lsu_valid_i, lsu_trans_id_i, lsu_is_store_i,
               lsu_vaddr_i, lsu_be_i, commit_ack_i, commit_drop_i, commit_pointer_i,
               commit_pc_i, commit_rd_i, commit_wdata_i, ex_valid_i, priv_lvl_i,
        input  rvfi_valid_o, rvfi_order_o, rvfi_insn_o, rvfi_trap_o, rvfi_pc_o,
               rvfi_rd_addr_o, rvfi_rd_wdata_o, rvfi_rs1_rdata_o, rvfi_rs2_rdata_o,
               rvfi_mem_addr_o, rvfi_mem_rmask_o, rvfi_mem_wmask_o, rvfi_mode_o, miss_o
    );
endinterface

// File: rtl/rvfi_retire_tracker.sv
// RVFI retirement tracker: stores issue-time data (instruction, operands, LSU access)
// per scoreboard trans_id and joins it with commit-port data into one registered RVFI
// record per committed, non-dropped instruction, numbered in program order.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   bus    : rvfi_retire_tracker_if.slave (issue/LSU/commit probes in, RVFI records out)
module rvfi_retire_tracker #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned TRANS_ID_BITS   = 3,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned ILEN            = 32
) (
    input logic                  clk_i,
    input logic                  rst_i,
    rvfi_retire_tracker_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** TRANS_ID_BITS;
    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned NP    = NR_COMMIT_PORTS;
    localparam int unsigned TB    = TRANS_ID_BITS;

    // Issue-time table
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] mem_valid_q;
    logic [ILEN-1:0]  insn_q     [DEPTH];
    logic [XLEN-1:0]  rs1_q      [DEPTH];
    logic [XLEN-1:0]  rs2_q      [DEPTH];
    logic             is_store_q [DEPTH];
    logic [XLEN-1:0]  vaddr_q    [DEPTH];
    logic [BE_W-1:0]  be_q       [DEPTH];

    logic [63:0] order_q, order_d;
    logic        miss_q, miss_d;

    logic [TB-1:0] cptr [NP];

    // Registered record fields (_q) and their next values (_d)
    logic [NP-1:0]        rec_valid_q, rec_valid_d;
    logic [NP*64-1:0]     rec_order_q, rec_order_d;
    logic [NP*ILEN-1:0]   rec_insn_q, rec_insn_d;
    logic [NP-1:0]        rec_trap_q, rec_trap_d;
    logic [NP*XLEN-1:0]   rec_pc_q, rec_pc_d;
    logic [NP*5-1:0]      rec_rd_q, rec_rd_d;
    logic [NP*XLEN-1:0]   rec_wdata_q, rec_wdata_d;
    logic [NP*XLEN-1:0]   rec_rs1_q, rec_rs1_d;
    logic [NP*XLEN-1:0]   rec_rs2_q, rec_rs2_d;
    logic [NP*XLEN-1:0]   rec_addr_q, rec_addr_d;
    logic [NP*BE_W-1:0]   rec_rmask_q, rec_rmask_d;
    logic [NP*BE_W-1:0]   rec_wmask_q, rec_wmask_d;
    logic [NP*2-1:0]      rec_mode_q, rec_mode_d;

    // Per-port commit index
    always_comb begin : commit_ptr_split
        for (int p = 0; p < NP; p++) begin
            cptr[p] = bus.commit_pointer_i[p*TB +: TB];
        end
    end

    // Build next-cycle records from pre-write table contents; non-dropped acks are
    // numbered consecutively from the current counter in port order.
    always_comb begin : record_build
        logic [63:0]   retired;
        logic          trap;
        logic          hit;
        logic [4:0]    rd;
        retired     = '0;
        trap        = 1'b0;
        hit         = 1'b0;
        rd          = '0;
        rec_valid_d = '0;
        rec_order_d = '0;
        rec_insn_d  = '0;
        rec_trap_d  = '0;
        rec_pc_d    = '0;
        rec_rd_d    = '0;
        rec_wdata_d = '0;
        rec_rs1_d   = '0;
        rec_rs2_d   = '0;
        rec_addr_d  = '0;
        rec_rmask_d = '0;
        rec_wmask_d = '0;
        rec_mode_d  = '0;
        miss_d      = miss_q;
        for (int p = 0; p < NP; p++) begin
            // Any acked read of an empty slot (dropped or not) flags a miss.
            if (bus.commit_ack_i[p] && !valid_q[cptr[p]]) begin
                miss_d = 1'b1;
            end
            if (bus.commit_ack_i[p] && !bus.commit_drop_i[p]) begin
                trap = (p == 0) && bus.ex_valid_i;
                hit  = valid_q[cptr[p]];
                rd   = bus.commit_rd_i[p*5 +: 5];
                rec_valid_d[p]              = 1'b1;
                rec_order_d[p*64 +: 64]     = order_q + retired;
                retired                     = retired + 64'd1;
                rec_trap_d[p]               = trap;
                rec_pc_d[p*XLEN +: XLEN]    = bus.commit_pc_i[p*XLEN +: XLEN];
                rec_rd_d[p*5 +: 5]          = trap ? 5'd0 : rd;
                rec_wdata_d[p*XLEN +: XLEN] = (trap || rd == 5'd0) ? XLEN'(0)
                                              : bus.commit_wdata_i[p*XLEN +: XLEN];
                rec_mode_d[p*2 +: 2]        = bus.priv_lvl_i;
                if (hit) begin
                    rec_insn_d[p*ILEN +: ILEN] = insn_q[cptr[p]];
                    rec_rs1_d[p*XLEN +: XLEN]  = rs1_q[cptr[p]];
                    rec_rs2_d[p*XLEN +: XLEN]  = rs2_q[cptr[p]];
                    if (mem_valid_q[cptr[p]]) begin
                        rec_addr_d[p*XLEN +: XLEN] = vaddr_q[cptr[p]];
                        if (is_store_q[cptr[p]]) begin
                            rec_wmask_d[p*BE_W +: BE_W] = be_q[cptr[p]];
                        end else begin
                            rec_rmask_d[p*BE_W +: BE_W] = be_q[cptr[p]];
                        end
                    end
                end
            end
        end
        order_d = order_q + retired;
    end

    // Control state: record registers, counter, miss flag, valid bits.
    // Commit clears go first so a same-cycle issue to that slot re-fills it.
    always_ff @(posedge clk_i) begin : state_update
        if (rst_i) begin
            valid_q     <= '0;
            mem_valid_q <= '0;
            order_q     <= '0;
            miss_q      <= 1'b0;
            rec_valid_q <= '0;
            rec_order_q <= '0;
            rec_insn_q  <= '0;
            rec_trap_q  <= '0;
            rec_pc_q    <= '0;
            rec_rd_q    <= '0;
            rec_wdata_q <= '0;
            rec_rs1_q   <= '0;
            rec_rs2_q   <= '0;
            rec_addr_q  <= '0;
            rec_rmask_q <= '0;
            rec_wmask_q <= '0;
            rec_mode_q  <= '0;
        end else begin
            order_q     <= order_d;
            miss_q      <= miss_d;
            rec_valid_q <= rec_valid_d;
            rec_order_q <= rec_order_d;
            rec_insn_q  <= rec_insn_d;
            rec_trap_q  <= rec_trap_d;
            rec_pc_q    <= rec_pc_d;
            rec_rd_q    <= rec_rd_d;
            rec_wdata_q <= rec_wdata_d;
            rec_rs1_q   <= rec_rs1_d;
            rec_rs2_q   <= rec_rs2_d;
            rec_addr_q  <= rec_addr_d;
            rec_rmask_q <= rec_rmask_d;
            rec_wmask_q <= rec_wmask_d;
            rec_mode_q  <= rec_mode_d;
            for (int p = 0; p < NP; p++) begin
                if (bus.commit_ack_i[p]) begin
                    valid_q[cptr[p]] <= 1'b0;
                end
            end
            if (bus.flush_i) begin
                valid_q     <= '0;
                mem_valid_q <= '0;
            end else begin
                if (bus.issue_valid_i) begin
                    valid_q[bus.issue_pointer_i]     <= 1'b1;
                    mem_valid_q[bus.issue_pointer_i] <= 1'b0;
                end
                // LSU after issue: wins on a shared index
                if (bus.lsu_valid_i) begin
                    mem_valid_q[bus.lsu_trans_id_i] <= 1'b1;
                end
            end
        end
    end

    // Table payload; no reset needed since valid bits gate every read.
    always_ff @(posedge clk_i) begin : table_data
        if (!rst_i && !bus.flush_i) begin
            if (bus.issue_valid_i) begin
                insn_q[bus.issue_pointer_i] <= bus.is_compressed_i
                                               ? ILEN'(bus.instruction_i[15:0])
                                               : bus.instruction_i;
                rs1_q[bus.issue_pointer_i]  <= bus.rs1_fwd_i;
                rs2_q[bus.issue_pointer_i]  <= bus.rs2_fwd_i;
            end
            if (bus.lsu_valid_i) begin
                is_store_q[bus.lsu_trans_id_i] <= bus.lsu_is_store_i;
                vaddr_q[bus.lsu_trans_id_i]    <= bus.lsu_vaddr_i;
                be_q[bus.lsu_trans_id_i]       <= bus.lsu_be_i;
            end
        end
    end

    assign bus.rvfi_valid_o     = rec_valid_q;
    assign bus.rvfi_order_o     = rec_order_q;
    assign bus.rvfi_insn_o      = rec_insn_q;
    assign bus.rvfi_trap_o      = rec_trap_q;
    assign bus.rvfi_pc_o        = rec_pc_q;
    assign bus.rvfi_rd_addr_o   = rec_rd_q;
    assign bus.rvfi_rd_wdata_o  = rec_wdata_q;
    assign bus.rvfi_rs1_rdata_o = rec_rs1_q;
    assign bus.rvfi_rs2_rdata_o = rec_rs2_q;
    assign bus.rvfi_mem_addr_o  = rec_addr_q;
    assign bus.rvfi_mem_rmask_o = rec_rmask_q;
    assign bus.rvfi_mem_wmask_o = rec_wmask_q;
    assign bus.rvfi_mode_o      = rec_mode_q;
    assign bus.miss_o           = miss_q;

endmodule
